// File: rtl/lfsr_prob_gen.sv
// Sequential Bernoulli word generator: a Fibonacci LFSR, advanced PBITS steps per cycle,
// fills one NCH-bit word per channel-slot and presents it on a valid/ready stream.
module lfsr_prob_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int               NCH          = 8,
    parameter int               PBITS        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic [WIDTH-1:0]       seed,
    input  logic [NCH*PBITS-1:0]   prob,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH-1:0]         out_bits,
    output logic                   err_lockup,
    output logic [1:0]             dbg_fsm,
    output logic [WIDTH-1:0]       dbg_lfsr
);

    localparam int             CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NCH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. Producers hold data steady while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HOLD = 2'd2} fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [WIDTH-1:0]      lfsr_q, lfsr_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [NCH*PBITS-1:0]  prob_q, prob_d;
    logic [NCH-1:0]        bits_q, bits_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      adv;
    logic [PBITS-1:0]      slice;
    logic [PBITS-1:0]      ch_prob;
    logic                  seed_take;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < PBITS; i++) begin
            t = {t[WIDTH-2:0], ^(t & TAPS)};
        end
        return t;
    endfunction

    assign seed_ready = !rst;
    assign seed_take  = seed_valid && seed_ready;
    assign out_valid  = (fsm_q == HOLD);
    assign out_bits   = bits_q;
    assign err_lockup = err_q;
    assign dbg_fsm    = fsm_q;
    assign dbg_lfsr   = lfsr_q;

    always_comb begin
        fsm_d   = fsm_q;
        lfsr_d  = lfsr_q;
        ch_d    = ch_q;
        prob_d  = prob_q;
        bits_d  = bits_q;
        err_d   = err_q;
        adv     = advance(lfsr_q);
        slice   = adv[PBITS-1:0];
        ch_prob = prob_q[ch_q*PBITS +: PBITS];

        // A seed load wins over everything else, including a pending partial word.
        if (seed_take) begin
            lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
            fsm_d  = FILL;
            ch_d   = '0;
            prob_d = prob;
            err_d  = 1'b0;
        end else begin
            case (fsm_q)
                IDLE: fsm_d = IDLE;
                FILL: begin
                    // The bit still uses the (zero) slice even when the state is recovered.
                    lfsr_d       = (adv == '0) ? DEFAULT_SEED : adv;
                    err_d        = err_q | (adv == '0);
                    bits_d[ch_q] = (slice < ch_prob);
                    if (ch_q == LAST) begin
                        fsm_d = HOLD;
                        ch_d  = '0;
                    end else begin
                        ch_d = ch_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        fsm_d  = FILL;
                        ch_d   = '0;
                        prob_d = prob;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            lfsr_q <= DEFAULT_SEED;
            ch_q   <= '0;
            prob_q <= '0;
            bits_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            lfsr_q <= lfsr_d;
            ch_q   <= ch_d;
            prob_q <= prob_d;
            bits_q <= bits_d;
            err_q  <= err_d;
        end
    end

endmodule
